arb_mux: RTL and testbench

Parametrised N-input valid/ready multiplexer with a round-robin arbiter and a registered output stage. It is the sequential successor to the core's combinational `mux`. It merges several request streams (e.g. fetch/LSU/debug bus masters) onto one downstream port. A forced-select mode keeps the legacy address-driven selection available. One clock domain; sits between requesters and a single shared consumer.

---
 rtl/arb_mux.sv | 101 ++++++++++
 tb/tb_arb_mux.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux.sv
// Round-robin / forced-select valid-ready multiplexer with a registered output stage.
// Merges INPUTS request streams onto one downstream port; the pointer wraps at INPUTS.
module arb_mux #(
  parameter  int DATA_WIDTH = 32,
  parameter  int INPUTS     = 4,
  localparam int SEL_W      = $clog2(INPUTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data [INPUTS],
  input  logic [INPUTS-1:0]     in_valid,
  output logic [INPUTS-1:0]     in_ready,
  input  logic                  force_en,
  input  logic [SEL_W-1:0]      force_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [SEL_W-1:0]      out_src,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam logic [SEL_W:0]   INPUTS_W = (SEL_W+1)'(INPUTS);
  localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(INPUTS-1);

  logic [DATA_WIDTH-1:0] out_data_r;
  logic [SEL_W-1:0]      out_src_r;
  logic                  out_valid_r;
  logic [SEL_W-1:0]      last_r;

  logic                  load_en_s;
  logic                  rr_found_s;
  logic [SEL_W-1:0]      rr_idx_s;
  logic [SEL_W:0]        cand_s;
  logic                  rr_pick_s;
  logic                  force_in_range_s;
  logic                  win_found_s;
  logic [SEL_W-1:0]      win_idx_s;
  logic                  xfer_s;

  // Round-robin search starting one past the last granted channel, modulo INPUTS.
  always_comb begin
    rr_found_s = 1'b0;
    rr_idx_s   = '0;
    cand_s     = '0;
    rr_pick_s  = 1'b0;
    for (int k = 1; k <= INPUTS; k++) begin
      cand_s     = {1'b0, last_r} + (SEL_W+1)'(k);
      cand_s     = (cand_s >= INPUTS_W) ? (cand_s - INPUTS_W) : cand_s;
      rr_pick_s  = !rr_found_s && in_valid[cand_s[SEL_W-1:0]];
      rr_idx_s   = rr_pick_s ? cand_s[SEL_W-1:0] : rr_idx_s;
      rr_found_s = rr_found_s | rr_pick_s;
    end
  end

  // Winner selection: forced mode only ever grants force_addr, and only when in range.
  always_comb begin
    load_en_s        = !out_valid_r || out_ready;
    force_in_range_s = ({1'b0, force_addr} < INPUTS_W);
    if (force_en) begin
      if (force_in_range_s) begin
        win_found_s = in_valid[force_addr];
      end else begin
        win_found_s = 1'b0;
      end
      win_idx_s = force_addr;
    end else begin
      win_found_s = rr_found_s;
      win_idx_s   = rr_idx_s;
    end
    xfer_s = !rst && load_en_s && win_found_s;
  end

  // One-hot accept towards the winning channel.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < INPUTS; i++) begin
      in_ready[i] = xfer_s && (win_idx_s == SEL_W'(i));
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_r  <= '0;
      out_src_r   <= '0;
      out_valid_r <= 1'b0;
      last_r      <= LAST_RST;
    end else if (xfer_s) begin
      out_data_r  <= in_data[win_idx_s];
      out_src_r   <= win_idx_s;
      out_valid_r <= 1'b1;
      last_r      <= force_en ? last_r : win_idx_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_data  = out_data_r;
  assign out_src   = out_src_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench for arb_mux: a 4-input and a 3-input instance, each checked
// against a behavioural arbitration model plus directed scenario checks.
module tb_arb_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_force_en, a_out_ready, a_out_valid;
  logic [7:0] a_in_data [4];
  logic [3:0] a_in_valid, a_in_ready;
  logic [1:0] a_force_addr, a_out_src;
  logic [7:0] a_out_data;

  logic       b_rst, b_force_en, b_out_ready, b_out_valid;
  logic [7:0] b_in_data [3];
  logic [2:0] b_in_valid, b_in_ready;
  logic [1:0] b_force_addr, b_out_src;
  logic [7:0] b_out_data;

  arb_mux #(.DATA_WIDTH(8), .INPUTS(4)) dut_a (
    .clk(clk), .rst(a_rst), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .force_en(a_force_en), .force_addr(a_force_addr), .out_data(a_out_data), .out_src(a_out_src),
    .out_valid(a_out_valid), .out_ready(a_out_ready));

  arb_mux #(.DATA_WIDTH(8), .INPUTS(3)) dut_b (
    .clk(clk), .rst(b_rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .force_en(b_force_en), .force_addr(b_force_addr), .out_data(b_out_data), .out_src(b_out_src),
    .out_valid(b_out_valid), .out_ready(b_out_ready));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: who should be granted, or -1.
  function automatic int rr_pick(input int n, input int last, input logic [3:0] v,
                                 input logic fen, input int faddr);
    int c;
    if (fen) begin
      if (faddr < n && v[faddr[1:0]]) return faddr;
      return -1;
    end
    for (int k = 1; k <= n; k++) begin
      c = (last + k) % n;
      if (v[c[1:0]]) return c;
    end
    return -1;
  endfunction

  bit          ma_valid = 1'b0;
  int          ma_last = 3;
  int          wa;
  logic [15:0] qa[$];
  logic [15:0] ea;
  bit          mb_valid = 1'b0;
  int          mb_last = 2;
  int          wb;
  logic [15:0] qb[$];
  logic [15:0] eb;

  // Model A: predicts in_ready / out_valid and pushes expected words.
  initial forever begin
    @(negedge clk);
    if (a_rst) begin
      chk("a_rst_ready", 32'(a_in_ready), 32'd0);
      ma_valid = 1'b0;
      ma_last  = 3;
      qa.delete();
    end else begin
      wa = (!ma_valid || a_out_ready) ?
           rr_pick(4, ma_last, a_in_valid, a_force_en, int'(a_force_addr)) : -1;
      chk("a_ready", 32'(a_in_ready), (wa >= 0) ? (32'd1 << wa) : 32'd0);
      chk("a_valid", 32'(a_out_valid), 32'(ma_valid));
      if (wa >= 0) begin
        qa.push_back({a_in_data[wa[1:0]], 8'(wa)});
        ma_valid = 1'b1;
        if (!a_force_en) ma_last = wa;
      end else if (a_out_ready) begin
        ma_valid = 1'b0;
      end
    end
  end

  // Monitor A: compares each consumed word against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (!a_rst && a_out_valid && a_out_ready) begin
      chk("a_sb_nonempty", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) begin
        ea = qa.pop_front();
        chk("a_data", 32'(a_out_data), 32'(ea[15:8]));
        chk("a_src", 32'(a_out_src), 32'(ea[7:0]));
      end
    end
  end

  // Model B (three channels).
  initial forever begin
    @(negedge clk);
    if (b_rst) begin
      chk("b_rst_ready", 32'(b_in_ready), 32'd0);
      mb_valid = 1'b0;
      mb_last  = 2;
      qb.delete();
    end else begin
      wb = (!mb_valid || b_out_ready) ?
           rr_pick(3, mb_last, {1'b0, b_in_valid}, b_force_en, int'(b_force_addr)) : -1;
      chk("b_ready", 32'(b_in_ready), (wb >= 0) ? (32'd1 << wb) : 32'd0);
      chk("b_valid", 32'(b_out_valid), 32'(mb_valid));
      if (wb >= 0) begin
        qb.push_back({b_in_data[wb[1:0]], 8'(wb)});
        mb_valid = 1'b1;
        if (!b_force_en) mb_last = wb;
      end else if (b_out_ready) begin
        mb_valid = 1'b0;
      end
    end
  end

  // Monitor B.
  initial forever begin
    @(negedge clk);
    if (!b_rst && b_out_valid && b_out_ready) begin
      chk("b_sb_nonempty", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) begin
        eb = qb.pop_front();
        chk("b_data", 32'(b_out_data), 32'(eb[15:8]));
        chk("b_src", 32'(b_out_src), 32'(eb[7:0]));
      end
    end
  end

  task automatic seq_a;
    int prev;
    int pre;
    int cnt[4];
    a_rst = 1'b1; a_in_valid = 4'hF; a_out_ready = 1'b1; a_force_en = 1'b0; a_force_addr = 2'd0;
    for (int i = 0; i < 4; i++) a_in_data[i] = 8'(i);
    tick; tick;
    @(negedge clk);
    chk("rst_out_data", 32'(a_out_data), 32'd0);
    chk("rst_out_src", 32'(a_out_src), 32'd0);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    tick;
    a_rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick;
      @(negedge clk);
      chk("prio_src", 32'(a_out_src), 32'(k % 4));
      chk("prio_data", 32'(a_out_data), 32'(k % 4));
      chk("prio_valid", 32'(a_out_valid), 32'd1);
    end
    tick;
    a_in_valid = 4'b1010;
    prev = 0;
    for (int k = 0; k < 8; k++) begin
      tick;
      @(negedge clk);
      chk("sparse_ready02", 32'(a_in_ready & 4'b0101), 32'd0);
      chk("sparse_src_odd", 32'(a_out_src[0]), 32'd1);
      if (k > 0) chk("sparse_alternate", 32'(int'(a_out_src) != prev), 32'd1);
      prev = int'(a_out_src);
    end
    tick;
    a_in_valid = 4'hF; a_force_en = 1'b1; a_force_addr = 2'd2;
    tick;
    a_out_ready = 1'b0; a_force_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_data", 32'(a_out_data), 32'd2);
      chk("bp_valid", 32'(a_out_valid), 32'd1);
      chk("bp_ready", 32'(a_in_ready), 32'd0);
      tick;
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_nobubble", 32'(a_in_ready != 4'd0), 32'd1);
    tick;
    pre = ma_last;
    a_force_en = 1'b1; a_force_addr = 2'd2;
    for (int k = 0; k < 4; k++) begin
      tick;
      @(negedge clk);
      chk("force_src", 32'(a_out_src), 32'd2);
      chk("force_data", 32'(a_out_data), 32'd2);
    end
    tick;
    a_force_en = 1'b0;
    @(negedge clk);
    chk("force_resume", 32'(a_in_ready), 32'd1 << ((pre + 1) % 4));
    tick; tick;
    a_rst = 1'b1; a_out_ready = 1'b0;
    @(negedge clk);
    chk("mr_valid_before", 32'(a_out_valid), 32'd1);
    chk("mr_ready_rst", 32'(a_in_ready), 32'd0);
    tick;
    @(negedge clk);
    chk("mr_valid_after", 32'(a_out_valid), 32'd0);
    tick;
    a_rst = 1'b0; a_out_ready = 1'b1;
    @(negedge clk);
    chk("mr_first_grant", 32'(a_in_ready), 32'd1);
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int k = 0; k < 8; k++) begin
      tick;
      @(negedge clk);
      cnt[a_out_src]++;
    end
    for (int i = 0; i < 4; i++) chk("fair_count", 32'(cnt[i]), 32'd2);
  endtask

  task automatic seq_b;
    b_rst = 1'b1; b_in_valid = 3'b111; b_out_ready = 1'b1; b_force_en = 1'b0; b_force_addr = 2'd0;
    for (int i = 0; i < 3; i++) b_in_data[i] = 8'(10 + i);
    tick; tick;
    b_rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick;
      @(negedge clk);
      chk("b_wrap_src", 32'(b_out_src), 32'(k % 3));
      chk("b_wrap_data", 32'(b_out_data), 32'(10 + k % 3));
    end
    tick;
    b_force_en = 1'b1; b_force_addr = 2'd3;
    @(negedge clk);
    chk("b_f3_ready", 32'(b_in_ready), 32'd0);
    chk("b_f3_held", 32'(b_out_valid), 32'd1);
    tick;
    @(negedge clk);
    chk("b_f3_valid_fall", 32'(b_out_valid), 32'd0);
    chk("b_f3_ready2", 32'(b_in_ready), 32'd0);
    tick;
    b_force_en = 1'b0;
  endtask

  task automatic rand_a(input int n);
    for (int c = 0; c < n; c++) begin
      tick;
      a_in_valid   = 4'($urandom);
      a_out_ready  = ($urandom_range(0, 3) != 0);
      a_force_en   = ($urandom_range(0, 7) == 0);
      a_force_addr = 2'($urandom);
      a_rst        = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < 4; i++) a_in_data[i] = 8'($urandom);
    end
    tick;
    a_rst = 1'b0; a_in_valid = 4'd0; a_out_ready = 1'b1; a_force_en = 1'b0;
  endtask

  task automatic rand_b(input int n);
    for (int c = 0; c < n; c++) begin
      tick;
      b_in_valid   = 3'($urandom);
      b_out_ready  = ($urandom_range(0, 3) != 0);
      b_force_en   = ($urandom_range(0, 5) == 0);
      b_force_addr = 2'($urandom);
      b_rst        = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < 3; i++) b_in_data[i] = 8'($urandom);
    end
    tick;
    b_rst = 1'b0; b_in_valid = 3'd0; b_out_ready = 1'b1; b_force_en = 1'b0;
  endtask

  initial begin
    fork
      seq_a();
      seq_b();
    join
    fork
      rand_a(400);
      rand_b(400);
    join
    tick; tick;
    @(negedge clk);
    chk("a_drain", 32'(qa.size()), 32'd0);
    chk("b_drain", 32'(qb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
